// File: rtl/block_swap_reg_file_if.sv
// Host port bundle for block_swap_reg_file: register read/write plus block-operation control.
interface block_swap_reg_file_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  op_start;
  logic [1:0]            op_code;
  logic [ADDR_WIDTH-1:0] op_addr_a;
  logic [ADDR_WIDTH-1:0] op_addr_b;
  logic [LEN_WIDTH-1:0]  op_len;
  logic                  op_busy;
  logic                  op_done;
  logic                  op_err;

  modport master (
    output we, addr_w, data_w, addr_r, op_start, op_code, op_addr_a, op_addr_b, op_len,
    input  data_r, op_busy, op_done, op_err
  );

  modport slave (
    input  we, addr_w, data_w, addr_r, op_start, op_code, op_addr_a, op_addr_b, op_len,
    output data_r, op_busy, op_done, op_err
  );
endinterface

// File: rtl/block_swap_reg_file.sv
// Register file with a SWAP/COPY/FILL block engine; SWAP takes 3 cycles/element, COPY/FILL 1, then a DONE cycle.
// SWAP_RANGE_CHECK_EN: reject ops running past the top of memory instead of wrapping.
module block_swap_reg_file #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  block_swap_reg_file_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_XFER = 3'd2;
  localparam logic [2:0] S_WR_B = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_SWAP = 2'b00;
  localparam logic [1:0] OP_COPY = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [2:0]            r_state;
  logic [1:0]            r_code;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [ADDR_WIDTH-1:0] r_b;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_idx;
  logic [DATA_WIDTH-1:0] r_fill;
  logic [DATA_WIDTH-1:0] r_tmp;

  logic [ADDR_WIDTH-1:0] w_a;
  logic [ADDR_WIDTH-1:0] w_b;
  logic                  w_last;
  logic                  w_busy;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_skip;

  assign w_a    = r_a + r_idx[ADDR_WIDTH-1:0];
  assign w_b    = r_b + r_idx[ADDR_WIDTH-1:0];
  assign w_last = (r_idx + LEN_WIDTH'(1)) == r_len;
  assign w_busy = (r_state == S_RD_A) || (r_state == S_XFER) || (r_state == S_WR_B);

`ifdef SWAP_RANGE_CHECK_EN
  logic                 r_err;
  logic [LEN_WIDTH:0]   w_end_a;
  logic [LEN_WIDTH:0]   w_end_b;
  logic                 w_reject;

  assign w_end_a  = (LEN_WIDTH+1)'(bus.op_addr_a) + (LEN_WIDTH+1)'(bus.op_len);
  assign w_end_b  = (LEN_WIDTH+1)'(bus.op_addr_b) + (LEN_WIDTH+1)'(bus.op_len);
  assign w_reject = (bus.op_code == OP_RSVD) ||
                    (w_end_a > (LEN_WIDTH+1)'(DEPTH)) || (w_end_b > (LEN_WIDTH+1)'(DEPTH));
  assign w_skip   = w_reject || (bus.op_len == '0);
  assign bus.op_err = r_err && (r_state == S_DONE);
`else
  assign w_skip   = (bus.op_code == OP_RSVD) || (bus.op_len == '0);
  assign bus.op_err = 1'b0;
`endif

  assign bus.op_busy = w_busy;
  assign bus.op_done = (r_state == S_DONE);
  assign bus.data_r  = r_mem[bus.addr_r];

  // Single write port: engine owns it in XFER/WR_B, host gets it whenever the engine is not busy.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == S_XFER) begin
      w_we = 1'b1;
      if (r_code == OP_SWAP) begin
        w_waddr = w_a;
        w_wdata = r_mem[w_b];
      end else if (r_code == OP_COPY) begin
        w_waddr = w_b;
        w_wdata = r_mem[w_a];
      end else begin
        w_waddr = w_b;
        w_wdata = r_fill;
      end
    end else if (r_state == S_WR_B) begin
      w_we    = 1'b1;
      w_waddr = w_b;
      w_wdata = r_tmp;
    end else if (!w_busy) begin
      w_we    = bus.we;
      w_waddr = bus.addr_w;
      w_wdata = bus.data_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_fill  <= '0;
      r_tmp   <= '0;
`ifdef SWAP_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.op_start) begin
            r_code <= bus.op_code;
            r_a    <= bus.op_addr_a;
            r_b    <= bus.op_addr_b;
            r_len  <= bus.op_len;
            r_fill <= bus.data_w;
            r_idx  <= '0;
`ifdef SWAP_RANGE_CHECK_EN
            r_err  <= w_reject;
`endif
            if (w_skip)                       r_state <= S_DONE;
            else if (bus.op_code == OP_SWAP)  r_state <= S_RD_A;
            else                              r_state <= S_XFER;
          end
        end
        S_RD_A: begin
          r_tmp   <= r_mem[w_a];
          r_state <= S_XFER;
        end
        S_XFER, S_WR_B: begin
          if (r_state == S_XFER && r_code == OP_SWAP) begin
            r_state <= S_WR_B;
          end else if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + LEN_WIDTH'(1);
            r_state <= (r_code == OP_SWAP) ? S_RD_A : S_XFER;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef SWAP_RANGE_CHECK_EN
          r_err   <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_swap_reg_file.sv
// Scenario bench for block_swap_reg_file: reference memory model feeds an expected-value queue.
module tb_block_swap_reg_file;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_d;
  int lat, bn;
  bit es;

  block_swap_reg_file_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  block_swap_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic push_model();
    for (int k = 0; k < DEPTH; k++) q.push_back(model[k]);
  endtask

  task automatic host_wr(input int addr, input logic [DW-1:0] d);
    @(posedge clk); #1;
    bus.we = 1'b1; bus.addr_w = AW'(addr); bus.data_w = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
    model[addr] = d;
  endtask

  task automatic model_op(input logic [1:0] code, input int a, input int b, input int n, input logic [DW-1:0] f);
    logic [DW-1:0] t;
    for (int i = 0; i < n; i++) begin
      int ai, bi;
      ai = (a + i) % DEPTH;
      bi = (b + i) % DEPTH;
      if (code == 2'b00) begin t = model[ai]; model[ai] = model[bi]; model[bi] = t; end
      else if (code == 2'b01) model[bi] = model[ai];
      else if (code == 2'b10) model[bi] = f;
    end
  endtask

  // Starts an op, scrambles the op inputs afterwards, optionally injects a host write + op_start mid-op.
  task automatic run_op(input logic [1:0] code, input int a, input int b, input int n, input logic [DW-1:0] d,
                        input bit swe, input int saddr, input int hw_cycle,
                        output int l, output int busy_n, output bit err_seen);
    @(posedge clk); #1;
    bus.op_code = code; bus.op_addr_a = AW'(a); bus.op_addr_b = AW'(b); bus.op_len = LW'(n);
    bus.data_w = d; bus.we = swe; bus.addr_w = AW'(saddr); bus.op_start = 1'b1;
    @(posedge clk); #1;
    bus.op_start = 1'b0; bus.we = 1'b0;
    bus.op_addr_a = AW'(a + 7); bus.op_addr_b = AW'(b + 3); bus.op_len = LW'(1); bus.data_w = 8'h3C;
    l = 1; busy_n = 0;
    while (bus.op_done !== 1'b1 && l < 2000) begin
      if (bus.op_busy === 1'b1) busy_n++;
      if (l == hw_cycle) begin
        bus.we = 1'b1; bus.addr_w = AW'(50); bus.data_w = 8'h12; bus.op_start = 1'b1; bus.op_code = 2'b01;
      end else begin
        bus.we = 1'b0; bus.op_start = 1'b0;
      end
      @(posedge clk); #1;
      l++;
    end
    err_seen = bus.op_err;
    bus.we = 1'b0; bus.op_start = 1'b0;
    if (bus.op_done !== 1'b1) l = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL reset mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
    checks++;
    if ({bus.op_busy, bus.op_done, bus.op_err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {bus.op_busy, bus.op_done, bus.op_err});
    end
  endtask

  task automatic test_swap();
    host_wr(5, 8'hAA); host_wr(9, 8'h55);
    run_op(2'b00, 5, 9, 1, 8'h00, 1'b0, 0, 0, lat, bn, es);
    model_op(2'b00, 5, 9, 1, 8'h00);
    checks++; if (lat !== 4) begin failures++; $display("FAIL swap_latency got=%0d exp=4", lat); end
    checks++; if (bn !== 3) begin failures++; $display("FAIL swap_busy got=%0d exp=3", bn); end
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL swap mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
  endtask

  task automatic test_copy();
    for (int i = 0; i < 4; i++) host_wr(10 + i, DW'(i + 1));
    run_op(2'b01, 10, 20, 4, 8'h00, 1'b0, 0, 0, lat, bn, es);
    model_op(2'b01, 10, 20, 4, 8'h00);
    checks++; if (lat !== 5) begin failures++; $display("FAIL copy_latency got=%0d exp=5", lat); end
    checks++; if (bn !== 4) begin failures++; $display("FAIL copy_busy got=%0d exp=4", bn); end
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL copy mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
  endtask

  task automatic test_fill_full();
    run_op(2'b10, 0, 0, 128, 8'hFF, 1'b0, 0, 60, lat, bn, es);
    model_op(2'b10, 0, 0, 128, 8'hFF);
    checks++; if (lat !== 129) begin failures++; $display("FAIL fill_latency got=%0d exp=129", lat); end
    checks++; if (bn !== 128) begin failures++; $display("FAIL fill_busy got=%0d exp=128", bn); end
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL fill mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
  endtask

  task automatic test_wrap();
    int addrs [6] = '{126, 127, 0, 1, 2, 3};
    for (int i = 0; i < 6; i++) host_wr(addrs[i], DW'(8'h10 + i));
    run_op(2'b00, 126, 0, 4, 8'h00, 1'b0, 0, 0, lat, bn, es);
`ifdef SWAP_RANGE_CHECK_EN
    checks++; if (lat !== 1) begin failures++; $display("FAIL wrap_latency got=%0d exp=1", lat); end
    checks++; if (es !== 1'b1) begin failures++; $display("FAIL wrap_err got=%0b exp=1", es); end
`else
    model_op(2'b00, 126, 0, 4, 8'h00);
    checks++; if (lat !== 13) begin failures++; $display("FAIL wrap_latency got=%0d exp=13", lat); end
    checks++; if (es !== 1'b0) begin failures++; $display("FAIL wrap_err got=%0b exp=0", es); end
`endif
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL wrap mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
  endtask

  task automatic test_overlap_and_start_write();
    host_wr(0, 8'h5A);
    run_op(2'b01, 0, 1, 4, 8'h00, 1'b0, 0, 0, lat, bn, es);
    model_op(2'b01, 0, 1, 4, 8'h00);
    // Host write in the start-accept cycle lands before the engine reads it.
    run_op(2'b01, 30, 31, 1, 8'h77, 1'b1, 30, 0, lat, bn, es);
    model[30] = 8'h77;
    model_op(2'b01, 30, 31, 1, 8'h00);
    checks++; if (lat !== 2) begin failures++; $display("FAIL startwr_latency got=%0d exp=2", lat); end
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL overlap mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
  endtask

  task automatic test_zero_and_reserved();
    run_op(2'b00, 40, 60, 0, 8'h00, 1'b0, 0, 0, lat, bn, es);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zero_len_latency got=%0d exp=1", lat); end
    checks++; if (bn !== 0) begin failures++; $display("FAIL zero_len_busy got=%0d exp=0", bn); end
    run_op(2'b11, 40, 60, 3, 8'h00, 1'b0, 0, 0, lat, bn, es);
    checks++; if (lat !== 1) begin failures++; $display("FAIL rsvd_latency got=%0d exp=1", lat); end
`ifdef SWAP_RANGE_CHECK_EN
    checks++; if (es !== 1'b1) begin failures++; $display("FAIL rsvd_err got=%0b exp=1", es); end
`else
    checks++; if (es !== 1'b0) begin failures++; $display("FAIL rsvd_err got=%0b exp=0", es); end
`endif
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL zero_rsvd mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
  endtask

  task automatic test_reset_mid_op();
    host_wr(5, 8'hC3); host_wr(9, 8'h3C);
    @(posedge clk); #1;
    bus.op_code = 2'b00; bus.op_addr_a = AW'(5); bus.op_addr_b = AW'(9); bus.op_len = LW'(2); bus.op_start = 1'b1;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.addr_r = AW'(5); #1; checks++;
    if (bus.data_r !== 8'h3C) begin failures++; $display("FAIL live_read mem[5] got=%h exp=3c", bus.data_r); end
    reset = 1'b1; #1;
    checks++;
    if ({bus.op_busy, bus.op_done, bus.op_err} !== 3'b000) begin
      failures++; $display("FAIL midreset_flags got=%b exp=000", {bus.op_busy, bus.op_done, bus.op_err});
    end
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL midreset mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
    reset = 1'b0;
    host_wr(70, 8'h81); host_wr(80, 8'h18);
    run_op(2'b00, 70, 80, 1, 8'h00, 1'b0, 0, 0, lat, bn, es);
    model_op(2'b00, 70, 80, 1, 8'h00);
    checks++; if (lat !== 4) begin failures++; $display("FAIL post_reset_latency got=%0d exp=4", lat); end
    push_model();
    for (int k = 0; k < DEPTH; k++) begin
      bus.addr_r = AW'(k); #1; exp_d = q.pop_front(); checks++;
      if (bus.data_r !== exp_d) begin failures++; $display("FAIL post_reset mem[%0d] got=%h exp=%h", k, bus.data_r, exp_d); end
    end
  endtask

  initial begin
    bus.we = 1'b0; bus.addr_w = '0; bus.data_w = '0; bus.addr_r = '0;
    bus.op_start = 1'b0; bus.op_code = '0; bus.op_addr_a = '0; bus.op_addr_b = '0; bus.op_len = '0;
    #23 reset = 1'b0;
    test_reset();
    test_swap();
    test_copy();
    test_fill_full();
    test_wrap();
    test_overlap_and_start_write();
    test_zero_and_reserved();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
